// File: rtl/memory_pkg.sv
// Shared types and helpers for the multi-port memory arbiter.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam int WORD_OFFSET = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module rr_arbiter
  import memory_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IW        = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        rr_ptr,
  output logic [IW-1:0]        grant,
  output logic                 any_req
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the closest requester is written last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_PORTS)) sum = sum - (IW+1)'(NUM_PORTS);
      idx = sum[IW-1:0];
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// NUM_PORTS clients share one word-addressed RAM; round-robin grant, fixed
// LATENCY cycles of access, then a one-cycle response to the granted port.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_PORTS-1:0]             resp_ready,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic [NUM_PORTS-1:0]             stall,
  output logic                             busy
);

  localparam int IW = idx_width(NUM_PORTS);
  localparam int MW = idx_width(MEM_WORDS);
  localparam int CW = idx_width(LATENCY);

  state_t                               state;
  logic [IW-1:0]                        rr_ptr, gnt_idx, pick;
  logic                                 any_req;
  logic                                 wr_q;
  logic [MW-1:0]                        addr_q;
  logic [DATA_WIDTH-1:0]                data_q;
  logic [CW-1:0]                        cnt;
  logic                                 commit;
  logic [NUM_PORTS-1:0][MW-1:0]         port_waddr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_wdata;
  logic [DATA_WIDTH-1:0]                mem [MEM_WORDS];
  logic                                 unused_addr;

  // Word index is the byte address shifted down, truncated so it wraps.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign port_waddr[g] = req_address[g*ADDR_WIDTH+WORD_OFFSET +: MW];
    assign port_wdata[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end
  assign unused_addr = ^req_address;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IW(IW)) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  assign commit = (state == ACCESS) && (cnt == '0);
  assign stall  = req_valid & ~resp_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt        <= '0;
      resp_ready <= '0;
      resp_data  <= '0;
    end else begin
      resp_ready <= '0;
      case (state)
        IDLE: if (any_req) begin
          gnt_idx <= pick;
          wr_q    <= req_write[pick];
          addr_q  <= port_waddr[pick];
          data_q  <= port_wdata[pick];
          cnt     <= CW'(LATENCY - 1);
          state   <= ACCESS;
        end
        ACCESS: if (commit) begin
          resp_data           <= wr_q ? data_q : mem[addr_q];
          resp_ready[gnt_idx] <= 1'b1;
          state               <= RESPOND;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESPOND: begin
          rr_ptr <= (gnt_idx == IW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && commit && wr_q) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: table vectors, directed corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MWORDS = 1024;
  localparam int L  = 4;

  logic              clock;
  logic              reset;
  logic [NP-1:0]     req_valid, req_write;
  logic [NP*AW-1:0]  req_address;
  logic [NP*DW-1:0]  req_data;
  logic [NP-1:0]     resp_ready, stall;
  logic [DW-1:0]     resp_data;
  logic              busy;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MWORDS), .LATENCY(L)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_ready(resp_ready), .resp_data(resp_data),
    .stall(stall), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no response expected resp_ready", name);
  endtask

  task automatic drive(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d);
    req_write[p]           = wr;
    req_address[p*AW +: AW] = a;
    req_data[p*DW +: DW]    = d;
    req_valid[p]           = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Isolated transaction from an idle arbiter; checks latency, stall, data.
  task automatic txn(input string name, input int p, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] expd, input bit drop);
    int lat;
    bit found;
    drive(p, wr, a, d);
    found = 0;
    lat   = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      lat++;
      if (resp_ready != '0) found = 1;
      else begin
        chk({name, ".stall"}, 64'(stall[p]), (drop && lat > 1) ? 64'd0 : 64'd1);
        if (drop && lat == 1) begin
          req_valid[p]            = 1'b0;
          req_data[p*DW +: DW]    = ~d;
          req_address[p*AW +: AW] = a ^ 32'h40;
        end
      end
    end
    if (!found) timeout(name);
    else begin
      chk({name, ".port"}, 64'(resp_ready), 64'(1 << p));
      chk({name, ".latency"}, 64'(lat), 64'(L + 1));
      chk({name, ".data"}, 64'(resp_data), 64'(expd));
      chk({name, ".stall_at_resp"}, 64'(stall[p]), 64'd0);
    end
    req_valid[p] = 1'b0;
    @(negedge clock);
    chk({name, ".idle_after"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_one(input string name, input int p, input logic [31:0] expd, output int lat);
    bit found;
    found = 0;
    lat   = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      lat++;
      if (resp_ready != '0) found = 1;
    end
    if (!found) timeout(name);
    else begin
      chk({name, ".port"}, 64'(resp_ready), 64'(1 << p));
      chk({name, ".data"}, 64'(resp_data), 64'(expd));
    end
  endtask

  // Reference model state for the random run.
  bit          pend [NP];
  bit          pw   [NP];
  logic [31:0] pa   [NP];
  logic [31:0] pd   [NP];
  logic [31:0] mmem [MWORDS];
  bit          known[MWORDS];

  initial begin
    int lat;
    int order[4];
    int mptr, exp_port, exp_cyc, cyc;
    bit mfree, free_next, quit;
    logic [31:0] rexp;
    int w;

    order = '{0, 1, 0, 1};
    vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[3] = '{0, 1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D};
    vecs[4] = '{1, 1'b1, 32'h0000_1000, 32'h0000_0011, 32'h0000_0011};
    vecs[5] = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0011};
    vecs[6] = '{2, 1'b1, 32'h0000_0008, 32'hAAAA_0008, 32'hAAAA_0008};
    vecs[7] = '{2, 1'b0, 32'hFFFF_F00B, 32'h0,         32'hAAAA_0008};
    vecs[8] = '{0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'h1234_5678};
    vecs[9] = '{1, 1'b0, 32'h0000_3FFC, 32'h0,         32'h1234_5678};

    reset       = 1'b1;
    req_valid   = '0;
    req_write   = '0;
    req_address = '0;
    req_data    = '0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst.resp_ready", 64'(resp_ready), 64'd0);
    chk("rst.resp_data", 64'(resp_data), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    req_valid = 3'b101;
    #1;
    chk("rst.stall", 64'(stall), 64'b101);
    @(negedge clock);
    chk("rst.hold_idle", 64'(busy), 64'd0);
    req_valid = '0;
    reset     = 1'b0;

    for (int i = 0; i < 10; i++)
      txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].wr, vecs[i].addr,
          vecs[i].data, vecs[i].expd, 1'b0);

    // Dropped valid and changed fields after grant do not affect the write
    txn("drop_wr", 0, 1'b1, 32'h20, 32'h77, 32'h77, 1'b1);
    txn("drop_rd", 2, 1'b0, 32'h20, 32'h0, 32'h77, 1'b0);

    // Contention from reset: grants alternate 0,1,0,1 at full throughput
    pulse_reset();
    drive(0, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 32'h40, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_one($sformatf("cont%0d", k), order[k], (order[k] == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D, lat);
      chk($sformatf("cont%0d.spacing", k), 64'(lat), (k == 0) ? 64'(L + 1) : 64'(L + 2));
    end
    req_valid = '0;
    @(negedge clock);

    // Wrap: pointer at 2 after serving port 1; ports 0 and 2 contend
    txn("wrap_setup", 1, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);
    drive(0, 1'b0, 32'h40, 32'h0);
    drive(2, 1'b0, 32'h08, 32'h0);
    wait_one("wrap_first", 2, 32'hAAAA_0008, lat);
    req_valid[2] = 1'b0;
    wait_one("wrap_second", 0, 32'hCAFE_F00D, lat);
    req_valid = '0;
    @(negedge clock);

    // Reset in ACCESS cycle 2, then in the final ACCESS cycle
    for (int r = 0; r < 2; r++) begin
      bit seen;
      drive(1, 1'b1, 32'h08, (r == 0) ? 32'h55 : 32'h66);
      for (int c = 0; c < ((r == 0) ? 2 : L); c++) @(negedge clock);
      chk($sformatf("rstacc%0d.busy_before", r), 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      reset     = 1'b0;
      req_valid = '0;
      chk($sformatf("rstacc%0d.busy_after", r), 64'(busy), 64'd0);
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        if (resp_ready != '0) seen = 1;
        @(negedge clock);
      end
      chk($sformatf("rstacc%0d.no_resp", r), 64'(seen), 64'd0);
      txn($sformatf("rstacc%0d.read", r), 0, 1'b0, 32'h08, 32'h0, 32'hAAAA_0008, 1'b0);
    end

    // Randomized traffic against the transaction model
    pulse_reset();
    for (int i = 0; i < MWORDS; i++) known[i] = 0;
    for (int p = 0; p < NP; p++) pend[p] = 0;
    mptr = 0; mfree = 1; free_next = 0; exp_port = -1; exp_cyc = 0; cyc = 0; quit = 0;
    for (int t = 0; t < 1500 && !quit; t++) begin
      @(negedge clock);
      cyc++;
      if (free_next) begin
        mfree     = 1;
        free_next = 0;
      end
      chk("rnd.busy", 64'(busy), 64'(!mfree));
      chk("rnd.stall", 64'(stall), 64'(req_valid & ~resp_ready));
      if (resp_ready != '0) begin
        if (exp_port < 0) begin
          chk("rnd.unexpected_resp", 64'(resp_ready), 64'd0);
          quit = 1;
        end else begin
          chk("rnd.port", 64'(resp_ready), 64'(1 << exp_port));
          chk("rnd.cycle", 64'(cyc), 64'(exp_cyc));
          w = int'(pa[exp_port][11:2]);
          if (pw[exp_port]) begin
            chk("rnd.wdata", 64'(resp_data), 64'(pd[exp_port]));
            mmem[w]  = pd[exp_port];
            known[w] = 1;
          end else if (known[w]) begin
            rexp = mmem[w];
            chk("rnd.rdata", 64'(resp_data), 64'(rexp));
          end
          pend[exp_port]      = 0;
          req_valid[exp_port] = 1'b0;
          free_next           = 1;
          exp_port            = -1;
        end
      end else if (exp_port >= 0 && cyc > exp_cyc) begin
        timeout("rnd.resp");
        quit = 1;
      end
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && ($urandom % 3 == 0)) begin
          w       = ($urandom % 2 == 1) ? int'($urandom % 8) : 1016 + int'($urandom % 8);
          pend[p] = 1;
          pw[p]   = 1'($urandom % 2);
          pa[p]   = ($urandom & 32'hFFFF_F000) | (32'(w) << 2) | ($urandom & 32'h3);
          pd[p]   = $urandom;
          drive(p, pw[p], pa[p], pd[p]);
        end else if (pend[p] && p == exp_port && ($urandom % 4 == 0)) begin
          req_data[p*DW +: DW]    = $urandom;
          req_address[p*AW +: AW] = $urandom;
        end
      end
      if (mfree) begin
        for (int k = NP - 1; k >= 0; k--)
          if (pend[(mptr + k) % NP]) exp_port = (mptr + k) % NP;
        if (exp_port >= 0) begin
          exp_cyc = cyc + L + 1;
          mfree   = 0;
          mptr    = (exp_port + 1) % NP;
        end
      end
    end
    req_valid = '0;
    repeat (L + 3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Parametrised successor to the fixed two-client memory controller.
- Serves NUM_PORTS cache clients (port 0 = L1I, port 1 = L1D, further ports for later DMA/extra cores) against one internal word-addressed backing RAM.
- Round-robin arbitration, per-port stall signals and a configurable fixed access latency.
- Sits between the L1 instances and main memory; each L1 drives one request port.

Parameters:
- NUM_PORTS, 2, number of client ports (1..8).
- ADDR_WIDTH, 32, byte-address width per port.
- DATA_WIDTH, 32, word width; byte address is word-aligned (low 2 bits ignored).
- MEM_WORDS, 1024, backing RAM depth in words (power of two).
- LATENCY, 4, cycles spent in ACCESS per transaction (>=1).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_PORTS  per-port request; held until resp_ready for that port
- req_write  in  NUM_PORTS  per-port 1=write, 0=read
- req_address  in  NUM_PORTS*ADDR_WIDTH  packed byte addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_PORTS*DATA_WIDTH  packed write data
- resp_ready  out  NUM_PORTS  one-cycle pulse, granted port only; read data valid / write committed
- resp_data  out  DATA_WIDTH  read data, valid while resp_ready pulses
- stall  out  NUM_PORTS  high while port has req_valid and is not receiving resp_ready this cycle
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, resp_ready=0, resp_data=0, busy=0, latency counter=0. stall is combinational and reflects req_valid immediately after reset. RAM contents are not cleared by reset.
- FSM:
  - IDLE: if any req_valid, grant the first requesting port at or after rr_ptr (wrapping NUM_PORTS-1 -> 0). On that edge, latch port index, write flag, word address and data; load counter = LATENCY-1; go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: counter decrements each cycle. When counter==0, perform the RAM read or write on that edge and go to RESPOND.
  - RESPOND: resp_ready[granted]=1 for exactly one cycle; resp_data holds the read word (or the written word, for writes). Set rr_ptr = granted+1, wrapping. Go to IDLE.
- Timing:
  - Request seen in IDLE at cycle 0 -> resp_ready high in cycle LATENCY+1.
  - Throughput is one transaction per LATENCY+2 cycles.
- Word address = req_address[ADDR_WIDTH-1:2] mod MEM_WORDS, so out-of-range addresses wrap.
- Request capture:
  - Request fields are sampled only at grant. Later changes to req_* on the granted port are ignored.
  - Dropping req_valid mid-transaction does not abort: the write still commits and resp_ready still pulses.
- Simultaneous requests: strict rotation from rr_ptr. With every port requesting continuously, grants cycle 0,1,..,N-1,0; no starvation.
- Read-after-write to the same address from another port returns the new data, because transactions are serialised.
- Reset mid-ACCESS: transaction is dropped and no RAM write occurs. Reset during the final ACCESS cycle also wins over the commit.
- Reset during RESPOND: resp_ready is forced to 0 from the next cycle.

Decomposition:
- Package memory_pkg holds:
  - state enum (IDLE, ACCESS, RESPOND);
  - WORD_OFFSET=2;
  - the arbiter index width function clog2(NUM_PORTS).
- One sub-module, rr_arbiter: combinational pick of the next requester given req mask and rr_ptr. Outputs grant index plus any_req.
- RAM is inferred inline as a synchronous single-port array.

Test Plan:
- Single read: port 0 reads 0x0000_0010 after TB preload word4=0xDEADBEEF -> resp_ready[0] in cycle 5 (LATENCY=4), resp_data=0xDEADBEEF, stall[0]=1 in cycles 0..4.
- Write then read: port 1 writes 0xCAFEF00D to 0x40, then port 0 reads 0x40 -> second response returns 0xCAFEF00D.
- Contention: ports 0 and 1 request together from reset -> port 0 served first, port 1 next; with both held continuously, the grant order is 0,1,0,1.
- Wrap: with NUM_PORTS=3 and rr_ptr=2, ports 0 and 2 request -> port 2 granted first, then port 0.
- Address wrap: MEM_WORDS=1024, write 0x11 to byte address 0x1000, read address 0x0 -> 0x11.
- Reset mid-access: port 1 writes 0x55 to 0x8 and reset is asserted in ACCESS cycle 2 -> no resp_ready, busy=0 next cycle, a later read of 0x8 returns the old value.
